dbus_arbiter: RTL and testbench

- Two-master arbiter for the shared data bus: master 0 is the core LSU path, master 1 is a secondary requester (DMA/debug).
- Grants exactly one master at a time and forwards its single-beat read/write to the dbus interconnect slave port.
- Returns the ack/rdata only to the owning master.
- Round-robin fairness on ties; a bus-timeout watchdog releases the bus and flags an error if the slave never acks.

---
 rtl/dbus_arbiter.sv | 156 +++++++++++++++
 tb/tb_dbus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master, single-beat arbiter in front of the dbus
// interconnect slave port. Master 0 is the LSU, master 1 is DMA/debug.
// Round-robin on ties, and a watchdog ends a transfer with an error if
// the slave never acks.
module dbus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    input  logic                flush_i,

    output logic                s_req_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    input  logic                s_ack_i,
    input  logic [DATA_W-1:0]   s_rdata_i,

    output logic [1:0]          gnt_o,
    output logic                busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;        // 0 = m0, 1 = m1
    logic             last_gnt_q, last_gnt_d;  // owner of the last completed transfer
    logic [CNT_W-1:0] cnt_q, cnt_d;            // BUSY cycles seen without s_ack_i

    logic m0_elig;
    logic m1_elig;
    logic pick;
    logic timeout;
    logic done;

    // Eligibility, tie-break and completion terms shared by next-state and outputs.
    always_comb begin
        m0_elig = m0_req_i && !flush_i;
        m1_elig = m1_req_i;
        // On a tie the master that did not go last wins; otherwise whoever asks.
        pick    = (m0_elig && m1_elig) ? ~last_gnt_q : m1_elig;
        // A same-cycle ack beats the watchdog.
        timeout = (cnt_q == CNT_LAST) && !s_ack_i;
        done    = s_ack_i || timeout;
    end

    // State, owner, fairness and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state: grant from IDLE, finish BUSY on ack or watchdog expiry.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_elig || m1_elig) begin
                    state_d = S_BUSY;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (done) begin
                    state_d    = S_IDLE;
                    last_gnt_d = owner_q;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: forward the owner's request and route completion back to it only.
    always_comb begin
        s_req_o    = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rdata_o = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rdata_o = '0;
        gnt_o      = 2'b00;
        busy_o     = 1'b0;
        if (state_q == S_BUSY) begin
            s_req_o = 1'b1;
            busy_o  = 1'b1;
            gnt_o   = owner_q ? 2'b10 : 2'b01;
            if (owner_q) begin
                s_addr_o   = m1_addr_i;
                s_wdata_o  = m1_wdata_i;
                s_we_o     = m1_we_i;
                s_sel_o    = m1_sel_i;
                m1_ack_o   = done;
                m1_err_o   = timeout;
                m1_rdata_o = s_ack_i ? s_rdata_i : '0;
            end else begin
                s_addr_o   = m0_addr_i;
                s_wdata_o  = m0_wdata_i;
                s_we_o     = m0_we_i;
                s_sel_o    = m0_sel_i;
                m0_ack_o   = done;
                m0_err_o   = timeout;
                m0_rdata_o = s_ack_i ? s_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: stimulus pushes expected completions
// and grant order; a negedge monitor pops and compares as the DUT answers.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        flush = 1'b0;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  gnt;
    logic        busy;

    int slv_wait0 = 0;
    int slv_wait1 = 0;
    logic [7:0] slv_cnt;

    int nchk  = 0;
    int npass = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
        int          nbusy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   gq[$];

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack),
        .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack),
        .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .flush_i(flush),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_we_o(s_we), .s_sel_o(s_sel), .s_ack_i(s_ack), .s_rdata_i(slv_rdata),
        .gnt_o(gnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Slave model: acks after a per-master number of wait cycles.
    assign s_ack = s_req && (int'(slv_cnt) == (gnt[1] ? slv_wait1 : slv_wait0));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             slv_cnt <= '0;
        else if (s_req && !s_ack) slv_cnt <= slv_cnt + 8'd1;
        else                    slv_cnt <= '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: grant order at the start of each BUSY run, bus fields every
    // BUSY cycle, completion contents and duration on each ack.
    initial begin : monitor
        int   bcnt;
        logic prev_busy;
        exp_t e;
        int   own;
        bcnt = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
                prev_busy = 1'b0;
            end else begin
                own = gnt[1] ? 1 : 0;
                if (busy && !prev_busy) begin
                    if (gq.size() == 0) chk("grant_unexpected", {62'd0, gnt}, 64'd0);
                    else chk("grant_owner", {62'd0, gnt}, (gq.pop_front() == 1) ? 64'd2 : 64'd1);
                end
                if (busy) begin
                    bcnt++;
                    if ((own == 1 ? q1.size() : q0.size()) == 0) begin
                        chk("busy_without_expectation", {63'd0, busy}, 64'd0);
                    end else begin
                        e = (own == 1) ? q1[0] : q0[0];
                        chk("s_addr", {32'd0, s_addr}, {32'd0, e.addr});
                        chk("s_wdata_we_sel", {27'd0, s_wdata, s_we, s_sel},
                            {27'd0, e.wdata, e.we, e.sel});
                        if (m0_ack || m1_ack) begin
                            chk("ack_route", {62'd0, m1_ack, m0_ack}, (own == 1) ? 64'd2 : 64'd1);
                            if (own == 1) begin
                                e = q1.pop_front();
                                chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, e.rdata});
                                chk("m1_err", {63'd0, m1_err}, {63'd0, e.err});
                                chk("nonowner_quiet", {31'd0, m0_err, m0_rdata}, 64'd0);
                            end else begin
                                e = q0.pop_front();
                                chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, e.rdata});
                                chk("m0_err", {63'd0, m0_err}, {63'd0, e.err});
                                chk("nonowner_quiet", {31'd0, m1_err, m1_rdata}, 64'd0);
                            end
                            chk("busy_cycles", 64'(bcnt), 64'(e.nbusy));
                            bcnt = 0;
                        end
                    end
                end else begin
                    bcnt = 0;
                    if (m0_ack || m1_ack) chk("ack_in_idle", {62'd0, m1_ack, m0_ack}, 64'd0);
                end
                prev_busy = busy;
            end
        end
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [3:0] sel);
        if (m == 1) begin
            m1_addr = a; m1_wdata = wd; m1_we = we; m1_sel = sel; m1_req = 1'b1;
        end else begin
            m0_addr = a; m0_wdata = wd; m0_we = we; m0_sel = sel; m0_req = 1'b1;
        end
    endtask

    task automatic push(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [3:0] sel, input logic [31:0] rd,
                        input logic err, input int nb);
        exp_t e;
        e.addr = a; e.wdata = wd; e.we = we; e.sel = sel;
        e.rdata = rd; e.err = err; e.nbusy = nb;
        if (m == 1) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where master m sees its ack.
    task automatic wait_ack(input int m);
        int n;
        n = 0;
        while (!((m == 1) ? m1_ack : m0_ack) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            nchk++;
            $display("FAIL ack_wait_m%0d: no ack within 64 cycles, required an ack", m);
        end
    endtask

    // Start at #1 after a posedge; return at #1 after the posedge ending the ack cycle.
    task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [3:0] sel, input logic [31:0] rd,
                          input logic err, input int nb);
        push(m, a, wd, we, sel, rd, err, nb);
        drive(m, a, wd, we, sel);
        @(negedge clk);
        wait_ack(m);
        @(posedge clk);
        #1;
        if (m == 1) m1_req = 1'b0;
        else m0_req = 1'b0;
    endtask

    initial begin
        // Reset values while rst_n is held low
        #1;
        chk("rst_s_req", {63'd0, s_req}, 64'd0);
        chk("rst_gnt_busy", {61'd0, gnt, busy}, 64'd0);
        chk("rst_acks_errs", {60'd0, m0_ack, m1_ack, m0_err, m1_err}, 64'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        chk("rst_s_fields", {s_addr, s_wdata} | {27'd0, s_we, s_sel}, 64'd0);
        do_reset();

        // Lone m0 read, zero-wait slave
        slv_wait0 = 0; slv_wait1 = 0; slv_rdata = 32'hCAFE_F00D;
        gq.push_back(0);
        @(negedge clk);
        chk("idle_before_req", {63'd0, s_req}, 64'd0);
        @(posedge clk); #1;
        do_txn(0, 32'h8000_0010, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b0, 1);
        @(negedge clk);
        chk("idle_after_ack", {63'd0, busy}, 64'd0);

        // Both masters request back-to-back: grants alternate starting with m0
        do_reset();
        slv_rdata = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            gq.push_back(0);
            gq.push_back(1);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    do_txn(0, 32'h100 + 32'(i * 4), 32'h0, 1'b0, 4'hF, 32'h1111_2222, 1'b0, 1);
            end
            begin
                for (int j = 0; j < 4; j++)
                    do_txn(1, 32'h200 + 32'(j * 4), 32'(j), 1'b1, 4'hF, 32'h1111_2222, 1'b0, 1);
            end
        join

        // m1 write with three slave wait states
        slv_rdata = 32'h0; slv_wait1 = 3;
        gq.push_back(1);
        do_txn(1, 32'h4000_0040, 32'h1234_5678, 1'b1, 4'b0011, 32'h0, 1'b0, 4);

        // Slave never acks m0: error completion on the 16th BUSY cycle, then m1
        slv_rdata = 32'hDEAD_BEEF; slv_wait0 = 255; slv_wait1 = 0;
        gq.push_back(0);
        gq.push_back(1);
        fork
            do_txn(0, 32'h8000_0020, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 16);
            begin
                @(posedge clk); #1;
                do_txn(1, 32'h300, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1);
            end
        join

        // Flush holds off the m0 grant for one cycle
        slv_wait0 = 0; slv_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        gq.push_back(0);
        push(0, 32'h8000_0030, 32'h0, 1'b0, 4'h1, 32'h5555_AAAA, 1'b0, 1);
        drive(0, 32'h8000_0030, 32'h0, 1'b0, 4'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_blocks_grant", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("grant_after_flush", {61'd0, gnt, busy}, 64'd3);
        wait_ack(0);
        @(posedge clk); #1;
        m0_req = 1'b0;

        // Asynchronous reset in the middle of a stalled transfer
        slv_wait0 = 255;
        gq.push_back(0);
        push(0, 32'h8000_0040, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 0);
        drive(0, 32'h8000_0040, 32'h0, 1'b0, 4'hF);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_s_req", {63'd0, s_req}, 64'd0);
        chk("async_rst_gnt_busy", {61'd0, gnt, busy}, 64'd0);
        chk("async_rst_no_ack", {62'd0, m0_ack, m0_err}, 64'd0);
        m0_req = 1'b0;
        q0.delete();
        q1.delete();
        gq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        slv_wait0 = 0; slv_wait1 = 0; slv_rdata = 32'h0BAD_F00D;
        gq.push_back(0);
        gq.push_back(1);
        fork
            do_txn(0, 32'h500, 32'h0, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 1);
            do_txn(1, 32'h600, 32'h0, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 1);
        join

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(q0.size() + q1.size() + gq.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
